// File: rtl/axi_lite_cut.sv
// axi_lite_cut: pipeline cut for one AXI-Lite link.
//
// Every channel (AW, W, B, AR, R) passes through its own two-entry spill register.
// Valid, payload and ready leaving the block all come straight from flops. Forward
// latency is one cycle, and each channel sustains one beat per cycle.
// DATA_WIDTH must be 32 or 64.
// With BYPASS=1 the block reduces to plain wires: no state, and rst_i is ignored.
//
// Ports:
//   clk_i       clock
//   rst_i       synchronous reset, active-high
//   slv_req_i   request from upstream master
//               {aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
//                ar_addr, ar_prot, ar_valid, r_ready}
//   slv_resp_o  response to upstream master
//               {aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid}
//   mst_req_o   request to downstream (same packing as slv_req_i)
//   mst_resp_i  response from downstream (same packing as slv_resp_o)
module axi_lite_cut #(
  parameter int unsigned  ADDR_WIDTH = 32,
  parameter int unsigned  DATA_WIDTH = 32,
  parameter bit           BYPASS     = 1'b0,
  localparam int unsigned STRB_W     = DATA_WIDTH / 8,
  localparam int unsigned REQ_W      = 2 * (ADDR_WIDTH + 3) + DATA_WIDTH + STRB_W + 5,
  localparam int unsigned RESP_W     = DATA_WIDTH + 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REQ_W-1:0]  slv_req_i,
  output logic [RESP_W-1:0] slv_resp_o,
  output logic [REQ_W-1:0]  mst_req_o,
  input  logic [RESP_W-1:0] mst_resp_i
);

  if (BYPASS) begin : g_bypass
    assign mst_req_o  = slv_req_i;
    assign slv_resp_o = mst_resp_i;
  end else begin : g_cut
    localparam int unsigned AxW = ADDR_WIDTH + 3;       // {addr, prot}
    localparam int unsigned WW  = DATA_WIDTH + STRB_W;  // {data, strb}
    localparam int unsigned BW  = 2;                    // resp
    localparam int unsigned RW  = DATA_WIDTH + 2;       // {data, resp}

    // "in" is the side a channel's beats arrive on, "out" the side they leave on.
    // For B and R that means in = downstream port and out = upstream port.
    logic [AxW-1:0] aw_in_pl, aw_out_pl, ar_in_pl, ar_out_pl;
    logic [WW-1:0]  w_in_pl, w_out_pl;
    logic [BW-1:0]  b_in_pl, b_out_pl;
    logic [RW-1:0]  r_in_pl, r_out_pl;
    logic aw_in_valid, aw_in_ready, aw_out_valid, aw_out_ready;
    logic w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic ar_in_valid, ar_in_ready, ar_out_valid, ar_out_ready;
    logic r_in_valid, r_in_ready, r_out_valid, r_out_ready;

    assign {aw_in_pl, aw_in_valid, w_in_pl, w_in_valid, b_out_ready,
            ar_in_pl, ar_in_valid, r_out_ready} = slv_req_i;
    assign {aw_out_ready, w_out_ready, b_in_pl, b_in_valid, ar_out_ready,
            r_in_pl, r_in_valid} = mst_resp_i;

    assign mst_req_o  = {aw_out_pl, aw_out_valid, w_out_pl, w_out_valid, b_in_ready,
                         ar_out_pl, ar_out_valid, r_in_ready};
    assign slv_resp_o = {aw_in_ready, w_in_ready, b_out_pl, b_out_valid, ar_in_ready,
                         r_out_pl, r_out_valid};

    // Channel index: 0 AW, 1 W, 2 B, 3 AR, 4 R.
    for (genvar c = 0; c < 5; c++) begin : g_chan
      localparam int unsigned PW = (c == 0 || c == 3) ? AxW :
                                   (c == 1)           ? WW  :
                                   (c == 2)           ? BW  : RW;

      logic [PW-1:0] in_pl, a_pl_q, a_pl_d, b_pl_q, b_pl_d;
      logic          in_valid, in_ready, out_valid, out_ready;
      logic          a_full_q, a_full_d, b_full_q, b_full_d;
      logic          in_hs, out_hs;

      // Readies and valids are masked by rst_i so that both read 0 during the
      // reset cycle, while the flops still hold their pre-reset contents.
      assign in_ready  = ~b_full_q & ~rst_i;
      assign out_valid = a_full_q & ~rst_i;
      assign in_hs     = in_valid & in_ready;
      assign out_hs    = out_valid & out_ready;

      always_comb begin
        a_full_d = a_full_q;
        b_full_d = b_full_q;
        a_pl_d   = a_pl_q;
        b_pl_d   = b_pl_q;
        if (!a_full_q) begin
          if (in_hs) begin
            a_full_d = 1'b1;
            a_pl_d   = in_pl;
          end
        end else if (!b_full_q) begin
          case ({in_hs, out_hs})
            2'b10: begin
              b_full_d = 1'b1;
              b_pl_d   = in_pl;
            end
            2'b01: a_full_d = 1'b0;
            2'b11: a_pl_d = in_pl;
            default: ;
          endcase
        end else if (out_hs) begin
          // Both slots full: ready is low, so only the drain can happen.
          b_full_d = 1'b0;
          a_pl_d   = b_pl_q;
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          a_full_q <= 1'b0;
          b_full_q <= 1'b0;
          a_pl_q   <= '0;
          b_pl_q   <= '0;
        end else begin
          a_full_q <= a_full_d;
          b_full_q <= b_full_d;
          a_pl_q   <= a_pl_d;
          b_pl_q   <= b_pl_d;
        end
      end

      if (c == 0) begin : g_aw
        assign in_pl        = aw_in_pl;
        assign in_valid     = aw_in_valid;
        assign aw_in_ready  = in_ready;
        assign aw_out_pl    = a_pl_q;
        assign aw_out_valid = out_valid;
        assign out_ready    = aw_out_ready;
      end else if (c == 1) begin : g_w
        assign in_pl       = w_in_pl;
        assign in_valid    = w_in_valid;
        assign w_in_ready  = in_ready;
        assign w_out_pl    = a_pl_q;
        assign w_out_valid = out_valid;
        assign out_ready   = w_out_ready;
      end else if (c == 2) begin : g_b
        assign in_pl       = b_in_pl;
        assign in_valid    = b_in_valid;
        assign b_in_ready  = in_ready;
        assign b_out_pl    = a_pl_q;
        assign b_out_valid = out_valid;
        assign out_ready   = b_out_ready;
      end else if (c == 3) begin : g_ar
        assign in_pl        = ar_in_pl;
        assign in_valid     = ar_in_valid;
        assign ar_in_ready  = in_ready;
        assign ar_out_pl    = a_pl_q;
        assign ar_out_valid = out_valid;
        assign out_ready    = ar_out_ready;
      end else begin : g_r
        assign in_pl       = r_in_pl;
        assign in_valid    = r_in_valid;
        assign r_in_ready  = in_ready;
        assign r_out_pl    = a_pl_q;
        assign r_out_valid = out_valid;
        assign out_ready   = r_out_ready;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_cut.sv
// Testbench for axi_lite_cut.
// Each channel is modelled as a FIFO queue that holds at most two beats.
// Expected ready is (size < 2). Expected valid is (size > 0). Expected payload is the
// queue head.
module tb_axi_lite_cut;
  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 32;
  localparam int unsigned SW     = DW / 8;
  localparam int unsigned REQ_W  = 2 * (AW + 3) + DW + SW + 5;
  localparam int unsigned RESP_W = DW + 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic byp_rst = 1'b0;
  always #5 clk = ~clk;

  // Upstream master drive
  logic [AW-1:0] s_aw_addr, s_ar_addr;
  logic [2:0]    s_aw_prot, s_ar_prot;
  logic          s_aw_valid, s_w_valid, s_b_ready, s_ar_valid, s_r_ready;
  logic [DW-1:0] s_w_data;
  logic [SW-1:0] s_w_strb;
  // Downstream slave drive
  logic          m_aw_ready, m_w_ready, m_b_valid, m_ar_ready, m_r_valid;
  logic [1:0]    m_b_resp, m_r_resp;
  logic [DW-1:0] m_r_data;
  // DUT outputs, unpacked
  logic [AW-1:0] o_aw_addr, o_ar_addr;
  logic [2:0]    o_aw_prot, o_ar_prot;
  logic          o_aw_valid, o_w_valid, o_b_ready, o_ar_valid, o_r_ready;
  logic [DW-1:0] o_w_data, o_r_data;
  logic [SW-1:0] o_w_strb;
  logic          o_aw_ready, o_w_ready, o_b_valid, o_ar_ready, o_r_valid;
  logic [1:0]    o_b_resp, o_r_resp;

  logic [REQ_W-1:0]  slv_req, mst_req, by_req_i, by_req_o;
  logic [RESP_W-1:0] slv_resp, mst_resp, by_resp_i, by_resp_o;

  assign slv_req  = {s_aw_addr, s_aw_prot, s_aw_valid, s_w_data, s_w_strb, s_w_valid, s_b_ready,
                     s_ar_addr, s_ar_prot, s_ar_valid, s_r_ready};
  assign mst_resp = {m_aw_ready, m_w_ready, m_b_resp, m_b_valid, m_ar_ready,
                     m_r_data, m_r_resp, m_r_valid};
  assign {o_aw_addr, o_aw_prot, o_aw_valid, o_w_data, o_w_strb, o_w_valid, o_b_ready,
          o_ar_addr, o_ar_prot, o_ar_valid, o_r_ready} = mst_req;
  assign {o_aw_ready, o_w_ready, o_b_resp, o_b_valid, o_ar_ready,
          o_r_data, o_r_resp, o_r_valid} = slv_resp;

  axi_lite_cut #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYPASS(1'b0)) dut (
    .clk_i(clk), .rst_i(rst), .slv_req_i(slv_req), .slv_resp_o(slv_resp),
    .mst_req_o(mst_req), .mst_resp_i(mst_resp)
  );

  axi_lite_cut #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYPASS(1'b1)) dut_byp (
    .clk_i(clk), .rst_i(byp_rst), .slv_req_i(by_req_i), .slv_resp_o(by_resp_o),
    .mst_req_o(by_req_o), .mst_resp_i(by_resp_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one queue per channel
  logic [63:0] q_aw[$], q_w[$], q_b[$], q_ar[$], q_r[$];

  // Compute handshakes from the current inputs and the model state. Advance one clock,
  // then update the queues. Returns 1 time unit after the posedge.
  task automatic tick();
    bit aw_i, aw_o, w_i, w_o, b_i, b_o, ar_i, ar_o, r_i, r_o;
    logic [63:0] aw_p, w_p, b_p, ar_p, r_p;
    aw_i = !rst && s_aw_valid && q_aw.size() < 2;
    aw_o = !rst && q_aw.size() > 0 && m_aw_ready;
    w_i  = !rst && s_w_valid && q_w.size() < 2;
    w_o  = !rst && q_w.size() > 0 && m_w_ready;
    b_i  = !rst && m_b_valid && q_b.size() < 2;
    b_o  = !rst && q_b.size() > 0 && s_b_ready;
    ar_i = !rst && s_ar_valid && q_ar.size() < 2;
    ar_o = !rst && q_ar.size() > 0 && m_ar_ready;
    r_i  = !rst && m_r_valid && q_r.size() < 2;
    r_o  = !rst && q_r.size() > 0 && s_r_ready;
    aw_p = 64'({s_aw_addr, s_aw_prot});
    w_p  = 64'({s_w_data, s_w_strb});
    b_p  = 64'(m_b_resp);
    ar_p = 64'({s_ar_addr, s_ar_prot});
    r_p  = 64'({m_r_data, m_r_resp});
    @(posedge clk);
    if (rst) begin
      q_aw.delete(); q_w.delete(); q_b.delete(); q_ar.delete(); q_r.delete();
    end else begin
      if (aw_o) void'(q_aw.pop_front());
      if (aw_i) q_aw.push_back(aw_p);
      if (w_o) void'(q_w.pop_front());
      if (w_i) q_w.push_back(w_p);
      if (b_o) void'(q_b.pop_front());
      if (b_i) q_b.push_back(b_p);
      if (ar_o) void'(q_ar.pop_front());
      if (ar_i) q_ar.push_back(ar_p);
      if (r_o) void'(q_r.pop_front());
      if (r_i) q_r.push_back(r_p);
    end
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] got;
    rst = 1'b1;
    tick();
    tick();
    got = {o_aw_ready, o_w_ready, o_ar_ready, o_b_ready, o_r_ready,
           o_aw_valid, o_w_valid, o_ar_valid, o_b_valid, o_r_valid};
    n_tests++;
    if (got !== 10'b0) begin
      n_fail++; $display("FAIL reset_during: got=%b exp=%b", got, 10'b0);
    end
    rst = 1'b0;
    #1;
    got = {o_aw_ready, o_w_ready, o_ar_ready, o_b_ready, o_r_ready,
           o_aw_valid, o_w_valid, o_ar_valid, o_b_valid, o_r_valid};
    n_tests++;
    if (got !== 10'b11111_00000) begin
      n_fail++; $display("FAIL reset_after: got=%b exp=%b", got, 10'b11111_00000);
    end
  endtask

  task automatic test_single_write();
    // cycle 0
    s_aw_addr = 32'h0000_1000; s_aw_prot = 3'd0; s_aw_valid = 1'b1;
    s_w_data = 32'hDEAD_BEEF; s_w_strb = 4'hF; s_w_valid = 1'b1;
    #1;
    tick();
    // cycle 1
    s_aw_valid = 1'b0; s_w_valid = 1'b0;
    #1;
    n_tests++;
    if ({o_aw_valid, o_aw_addr, o_aw_prot} !== {1'b1, 32'h0000_1000, 3'd0}) begin
      n_fail++;
      $display("FAIL wr_aw_out: got=%h exp=%h", {o_aw_valid, o_aw_addr, o_aw_prot},
               {1'b1, 32'h0000_1000, 3'd0});
    end
    n_tests++;
    if ({o_w_valid, o_w_data, o_w_strb} !== {1'b1, 32'hDEAD_BEEF, 4'hF}) begin
      n_fail++;
      $display("FAIL wr_w_out: got=%h exp=%h", {o_w_valid, o_w_data, o_w_strb},
               {1'b1, 32'hDEAD_BEEF, 4'hF});
    end
    tick();
    // cycle 2
    #1;
    n_tests++;
    if ({o_aw_valid, o_w_valid} !== 2'b00) begin
      n_fail++; $display("FAIL wr_drained: got=%b exp=00", {o_aw_valid, o_w_valid});
    end
    tick();
    // cycle 3: downstream answers
    m_b_valid = 1'b1; m_b_resp = 2'd0;
    #1;
    tick();
    // cycle 4
    m_b_valid = 1'b0;
    #1;
    n_tests++;
    if ({o_b_valid, o_b_resp} !== 3'b100) begin
      n_fail++; $display("FAIL wr_b_out: got=%b exp=100", {o_b_valid, o_b_resp});
    end
    tick();
    #1;
    n_tests++;
    if (o_b_valid !== 1'b0) begin
      n_fail++; $display("FAIL wr_b_drained: got=%b exp=0", o_b_valid);
    end
  endtask

  task automatic test_back_to_back();
    m_ar_ready = 1'b1; s_r_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      s_ar_valid = (k < 8); s_ar_addr = 32'(4 * k); s_ar_prot = 3'd0;
      m_r_valid = (k < 8); m_r_data = 32'(32'h100 + k); m_r_resp = 2'd0;
      #1;
      if (k < 8) begin
        n_tests++;
        if (o_ar_ready !== 1'b1) begin
          n_fail++; $display("FAIL b2b_ar_ready k=%0d: got=%b exp=1", k, o_ar_ready);
        end
      end
      if (k >= 1 && k <= 8) begin
        n_tests++;
        if ({o_ar_valid, o_ar_addr} !== {1'b1, 32'(4 * (k - 1))}) begin
          n_fail++;
          $display("FAIL b2b_ar k=%0d: got=%h exp=%h", k, {o_ar_valid, o_ar_addr},
                   {1'b1, 32'(4 * (k - 1))});
        end
        n_tests++;
        if ({o_r_valid, o_r_data} !== {1'b1, 32'(32'h100 + k - 1)}) begin
          n_fail++;
          $display("FAIL b2b_r k=%0d: got=%h exp=%h", k, {o_r_valid, o_r_data},
                   {1'b1, 32'(32'h100 + k - 1)});
        end
      end
      if (k == 9) begin
        n_tests++;
        if ({o_ar_valid, o_r_valid} !== 2'b00) begin
          n_fail++; $display("FAIL b2b_tail: got=%b exp=00", {o_ar_valid, o_r_valid});
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [35:0] beat[3];
    int idx = 0;
    int got = 0;
    bit acc;
    for (int i = 0; i < 3; i++) beat[i] = {$urandom, 4'($urandom)};
    m_w_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      s_w_valid = (idx < 3);
      if (idx < 3) {s_w_data, s_w_strb} = beat[idx];
      #1;
      n_tests++;
      if (o_w_ready !== (q_w.size() < 2)) begin
        n_fail++;
        $display("FAIL bp_ready c=%0d: got=%b exp=%b", c, o_w_ready, (q_w.size() < 2));
      end
      if (c >= 1) begin
        n_tests++;
        if ({o_w_valid, o_w_data, o_w_strb} !== {1'b1, beat[0]}) begin
          n_fail++;
          $display("FAIL bp_hold c=%0d: got=%h exp=%h", c, {o_w_valid, o_w_data, o_w_strb},
                   {1'b1, beat[0]});
        end
      end
      acc = s_w_valid && (q_w.size() < 2);
      tick();
      if (acc) idx++;
    end
    m_w_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      s_w_valid = (idx < 3);
      if (idx < 3) {s_w_data, s_w_strb} = beat[idx];
      #1;
      if (o_w_valid) begin
        n_tests++;
        if (got >= 3) begin
          n_fail++; $display("FAIL bp_extra_beat: got=%h exp=none", {o_w_data, o_w_strb});
        end else if ({o_w_data, o_w_strb} !== beat[got]) begin
          n_fail++;
          $display("FAIL bp_order %0d: got=%h exp=%h", got, {o_w_data, o_w_strb}, beat[got]);
        end
        got++;
      end
      acc = s_w_valid && (q_w.size() < 2);
      tick();
      if (acc) idx++;
    end
    s_w_valid = 1'b0;
    n_tests++;
    if (got !== 3) begin
      n_fail++; $display("FAIL bp_count: got=%0d exp=3", got);
    end
  endtask

  task automatic test_random_w();
    logic [35:0] beats[20];
    int idx = 0;
    int got = 0;
    int c = 0;
    bit acc;
    for (int i = 0; i < 20; i++) beats[i] = {$urandom, 4'($urandom)};
    s_w_valid = 1'b0;
    while (c < 160 && (got < 20 || c < 50)) begin
      // Once raised, the upstream valid stays up until its beat is accepted.
      if (!s_w_valid && idx < 20) s_w_valid = ($urandom_range(0, 3) != 0);
      if (idx < 20) {s_w_data, s_w_strb} = beats[idx];
      m_w_ready = (c % 2 == 1);
      #1;
      n_tests++;
      if ({o_w_ready, o_w_valid} !== {q_w.size() < 2, q_w.size() > 0}) begin
        n_fail++;
        $display("FAIL rnd_flags c=%0d: got=%b exp=%b", c, {o_w_ready, o_w_valid},
                 {q_w.size() < 2, q_w.size() > 0});
      end
      if (q_w.size() > 0) begin
        n_tests++;
        if ({o_w_data, o_w_strb} !== q_w[0][35:0]) begin
          n_fail++;
          $display("FAIL rnd_head c=%0d: got=%h exp=%h", c, {o_w_data, o_w_strb}, q_w[0][35:0]);
        end
      end
      if (o_w_valid && m_w_ready) begin
        n_tests++;
        if (got >= 20) begin
          n_fail++; $display("FAIL rnd_extra_beat: got=%h exp=none", {o_w_data, o_w_strb});
        end else if ({o_w_data, o_w_strb} !== beats[got]) begin
          n_fail++;
          $display("FAIL rnd_order %0d: got=%h exp=%h", got, {o_w_data, o_w_strb}, beats[got]);
        end
        got++;
      end
      acc = s_w_valid && (q_w.size() < 2);
      tick();
      if (acc) begin
        idx++;
        s_w_valid = 1'b0;
      end
      c++;
    end
    s_w_valid = 1'b0;
    m_w_ready = 1'b1;
    n_tests++;
    if (got !== 20) begin
      n_fail++; $display("FAIL rnd_count: got=%0d exp=20", got);
    end
  endtask

  task automatic test_reset_mid();
    m_ar_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_ar_valid = 1'b1; s_ar_addr = $urandom; s_ar_prot = 3'($urandom);
      #1;
      tick();
    end
    s_ar_valid = 1'b0;
    #1;
    n_tests++;
    if ({o_ar_valid, o_ar_ready} !== 2'b10) begin
      n_fail++; $display("FAIL rstmid_full: got=%b exp=10", {o_ar_valid, o_ar_ready});
    end
    rst = 1'b1;
    m_ar_ready = 1'b1;
    #1;
    n_tests++;
    if ({o_ar_valid, o_ar_ready, o_aw_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_during: got=%b exp=000", {o_ar_valid, o_ar_ready, o_aw_ready});
    end
    tick();
    rst = 1'b0;
    #1;
    n_tests++;
    if ({o_ar_valid, o_ar_ready} !== 2'b01) begin
      n_fail++; $display("FAIL rstmid_after: got=%b exp=01", {o_ar_valid, o_ar_ready});
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if (o_ar_valid !== (q_ar.size() > 0)) begin
        n_fail++;
        $display("FAIL rstmid_flush k=%0d: got=%b exp=%b", k, o_ar_valid, (q_ar.size() > 0));
      end
    end
  endtask

  task automatic test_bypass();
    logic [127:0] r1, r2;
    for (int i = 0; i < 6; i++) begin
      r1 = {$urandom, $urandom, $urandom, $urandom};
      r2 = {$urandom, $urandom, $urandom, $urandom};
      by_req_i  = r1[REQ_W-1:0];
      by_resp_i = r2[RESP_W-1:0];
      if (i == 0) begin
        by_req_i[REQ_W-AW-4] = 1'b1;   // aw_valid
        by_resp_i[RESP_W-1]  = 1'b1;   // downstream aw_ready
      end
      byp_rst = (i % 2 == 1);
      #1;
      n_tests++;
      if (by_req_o !== by_req_i) begin
        n_fail++; $display("FAIL byp_req %0d: got=%h exp=%h", i, by_req_o, by_req_i);
      end
      n_tests++;
      if (by_resp_o !== by_resp_i) begin
        n_fail++; $display("FAIL byp_resp %0d: got=%h exp=%h", i, by_resp_o, by_resp_i);
      end
      if (i == 0) begin
        n_tests++;
        if (by_resp_o[RESP_W-1] !== 1'b1) begin
          n_fail++; $display("FAIL byp_aw_ready: got=%b exp=1", by_resp_o[RESP_W-1]);
        end
      end
    end
    byp_rst = 1'b0;
  endtask

  initial begin
    s_aw_addr = '0; s_aw_prot = '0; s_aw_valid = 1'b0;
    s_w_data = '0; s_w_strb = '0; s_w_valid = 1'b0; s_b_ready = 1'b1;
    s_ar_addr = '0; s_ar_prot = '0; s_ar_valid = 1'b0; s_r_ready = 1'b1;
    m_aw_ready = 1'b1; m_w_ready = 1'b1; m_b_valid = 1'b0; m_b_resp = '0;
    m_ar_ready = 1'b1; m_r_valid = 1'b0; m_r_data = '0; m_r_resp = '0;
    by_req_i = '0; by_resp_i = '0;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_backpressure();
    test_random_w();
    test_reset_mid();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
